// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle op dispatcher: state encoding, job record and sizing helper.
package mc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    localparam int MC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } state_t;

    typedef struct packed {
        logic                mode;
        logic [MC_WIDTH-1:0] a;
        logic [MC_WIDTH-1:0] b;
        logic [MC_WIDTH-1:0] c;
    } mc_job_t;

    // Packed {mode, a, b, c} width for an arbitrary operand width.
    function automatic int jobBits(input int width);
        return 1 + 3 * width;
    endfunction

endpackage

// File: rtl/mc_op_dispatcher_if.sv
// Request, issue and status signals of the op dispatcher; the dispatcher takes the slave modport.
interface mc_op_dispatcher_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic             done;
    logic             busy;
    logic [7:0]       job_count;
    logic             timeout_err;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_c, done,
        input  in_ready, start, mode, op_a, op_b, op_c, busy, job_count, timeout_err
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_c, done,
        output in_ready, start, mode, op_a, op_b, op_c, busy, job_count, timeout_err
    );
endinterface

// File: rtl/mc_dispatch_fifo.sv
// Circular-buffer job FIFO for the dispatcher; entries are {mode, a, b, c}, no bypass from push to pop.
module mc_dispatch_fifo
    import mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pushEn,
    input  logic [jobBits(WIDTH)-1:0]  pushData,
    input  logic                       popEn,
    output logic [jobBits(WIDTH)-1:0]  popData,
    output logic                       full,
    output logic                       empty
);
    localparam int JW = jobBits(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [JW-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          doPush;
    logic          doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = pushEn && !full;
    assign doPop   = popEn && !empty;
    assign popData = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/mc_op_dispatcher.sv
// Job feeder for the multicycle datapath: queues requests, issues one at a time, counts retirements.
// Optional WAIT watchdog enabled by defining MC_DISPATCH_TIMEOUT_EN.
module mc_op_dispatcher
    import mc_pkg::*;
#(
    parameter int WIDTH   = MC_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    mc_op_dispatcher_if.slave   bus
);
    localparam int JW = jobBits(WIDTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : gBadParams
        $error("mc_op_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t        state;
    state_t        nextState;
    logic [JW-1:0] pushData;
    logic [JW-1:0] popData;
    logic [JW-1:0] holdJob;
    logic          full;
    logic          empty;
    logic          pushEn;
    logic          popEn;
    logic          retire;
    logic          abort;
    logic [7:0]    jobCount;

    assign pushEn   = bus.in_valid && !full;
    assign pushData = {bus.in_mode, bus.in_a, bus.in_b, bus.in_c};

    mc_dispatch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (pushEn),
        .pushData (pushData),
        .popEn    (popEn),
        .popData  (popData),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // done outranks the watchdog, and is meaningless outside WAIT.
    always_comb begin
        nextState = state;
        popEn     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    popEn     = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: nextState = WAIT;
            WAIT: begin
                if (bus.done) begin
                    retire    = 1'b1;
                    nextState = IDLE;
                end else if (abort) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdJob  <= '0;
            jobCount <= '0;
        end else begin
            if (popEn)  holdJob  <= popData;
            if (retire) jobCount <= jobCount + 1'b1;
        end
    end

`ifdef MC_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdCount;
    logic            errFlag;

    // Count reaching TIMEOUT-1 here means this is the TIMEOUT-th cycle spent in WAIT.
    assign abort = (wdCount == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdCount <= '0;
            errFlag <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wdCount <= '0;
            end else if (state == WAIT) begin
                wdCount <= wdCount + 1'b1;
            end
            if (state == WAIT && !bus.done && abort) errFlag <= 1'b1;
        end
    end

    assign bus.timeout_err = errFlag;
`else
    assign abort           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.in_ready  = !full;
    assign bus.start     = (state == ISSUE);
    assign bus.busy      = (state != IDLE);
    assign bus.job_count = jobCount;
    assign bus.mode      = holdJob[JW-1];
    assign bus.op_a      = holdJob[3*WIDTH-1:2*WIDTH];
    assign bus.op_b      = holdJob[2*WIDTH-1:WIDTH];
    assign bus.op_c      = holdJob[WIDTH-1:0];

endmodule

// File: tb/tb_mc_op_dispatcher.sv
// Randomised and directed bench for mc_op_dispatcher against a queue-based reference model.
// Honours MC_DISPATCH_TIMEOUT_EN the same way the design does.
module tb_mc_op_dispatcher;
    import mc_pkg::*;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mc_op_dispatcher_if #(.WIDTH(WIDTH)) bus ();

    mc_op_dispatcher #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      errors = 0;
    int      checks = 0;
    mc_job_t q[$];
    mc_job_t held;
    int      jobs;
    int      age;
    bit      errFlag;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        held    = '0;
        jobs    = 0;
        age     = -1;
        errFlag = 1'b0;
    endtask

    // age: -1 idle, 0 during the start cycle, k during the k-th cycle waiting for done.
    task automatic modelEdge(input bit v, input bit d, input mc_job_t j);
        bit acc;
        acc = v && (q.size() < DEPTH);
        if (age < 0) begin
            if (q.size() > 0) begin
                held = q.pop_front();
                age  = 0;
            end
        end else if (age == 0) begin
            age = 1;
        end else if (d) begin
            jobs++;
            age = -1;
        end
`ifdef MC_DISPATCH_TIMEOUT_EN
        else if (age == TIMEOUT) begin
            errFlag = 1'b1;
            age     = -1;
        end
`endif
        else begin
            age++;
        end
        if (acc) q.push_back(j);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".start"},    32'(bus.start),       32'(age == 0));
        checkOutput({tag, ".busy"},     32'(bus.busy),        32'(age >= 0));
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready),    32'(q.size() < DEPTH));
        checkOutput({tag, ".jobs"},     32'(bus.job_count),   32'(jobs % 256));
        checkOutput({tag, ".tmo"},      32'(bus.timeout_err), 32'(errFlag));
        checkOutput({tag, ".mode"},     32'(bus.mode),        32'(held.mode));
        checkOutput({tag, ".op_a"},     32'(bus.op_a),        32'(held.a));
        checkOutput({tag, ".op_b"},     32'(bus.op_b),        32'(held.b));
        checkOutput({tag, ".op_c"},     32'(bus.op_c),        32'(held.c));
    endtask

    function automatic mc_job_t randJob();
        mc_job_t j;
        j.mode = 1'($urandom);
        j.a    = 8'($urandom);
        j.b    = 8'($urandom);
        j.c    = 8'($urandom);
        return j;
    endfunction

    // Called on a falling edge: drive, let one rising edge pass, then check on the next falling edge.
    task automatic applyStimulus(input bit v, input bit d, input mc_job_t j, input string tag);
        bus.in_valid = v;
        bus.done     = d;
        bus.in_mode  = j.mode;
        bus.in_a     = j.a;
        bus.in_b     = j.b;
        bus.in_c     = j.c;
        @(posedge clk);
        modelEdge(v, d, j);
        @(negedge clk);
        checkModel(tag);
    endtask

    task automatic applyReset(input string tag);
        #2;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        #1;
        checkOutput({tag, ".start"},    32'(bus.start),       32'd0);
        checkOutput({tag, ".busy"},     32'(bus.busy),        32'd0);
        checkOutput({tag, ".jobs"},     32'(bus.job_count),   32'd0);
        checkOutput({tag, ".tmo"},      32'(bus.timeout_err), 32'd0);
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready),    32'd1);
        checkOutput({tag, ".mode"},     32'(bus.mode),        32'd0);
        checkOutput({tag, ".op_a"},     32'(bus.op_a),        32'd0);
        checkOutput({tag, ".op_b"},     32'(bus.op_b),        32'd0);
        checkOutput({tag, ".op_c"},     32'(bus.op_c),        32'd0);
        modelReset();
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    mc_job_t none;
    mc_job_t single;
    int      accepted;
    int      busyCycles;
    int      startSeen;

    initial begin
        none         = '0;
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        bus.in_mode  = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_c     = '0;
        modelReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyReset("rst0");

        // Single job with done five cycles after the start pulse.
        single = '{mode: 1'b1, a: 8'd5, b: 8'd3, c: 8'd2};
        applyStimulus(1'b1, 1'b0, single, "single.push");
        applyStimulus(1'b0, 1'b0, none, "single.e1");
        checkOutput("single.startHigh", 32'(bus.start), 32'd1);
        checkOutput("single.opA",       32'(bus.op_a),  32'd5);
        checkOutput("single.opB",       32'(bus.op_b),  32'd3);
        checkOutput("single.opC",       32'(bus.op_c),  32'd2);
        checkOutput("single.mode",      32'(bus.mode),  32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, none, "single.wait");
        applyStimulus(1'b0, 1'b1, none, "single.done");
        checkOutput("single.count", 32'(bus.job_count), 32'd1);
        checkOutput("single.idle",  32'(bus.busy),      32'd0);

        // Back-to-back pushes with done withheld: DEPTH queued plus one held.
        applyReset("rst1");
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.in_ready) accepted++;
            applyStimulus(1'b1, 1'b0, randJob(), "bp.push");
        end
        checkOutput("bp.accepted", 32'(accepted),     32'd5);
        checkOutput("bp.notReady", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, none, "bp.drain");
        checkOutput("bp.count", 32'(bus.job_count), 32'd5);

        // done pulses in IDLE and in ISSUE must not retire anything.
        applyStimulus(1'b0, 1'b1, none, "spur.idle");
        applyStimulus(1'b1, 1'b1, randJob(), "spur.push");
        applyStimulus(1'b0, 1'b1, none, "spur.pop");
        applyStimulus(1'b0, 1'b1, none, "spur.issue");
        checkOutput("spur.count", 32'(bus.job_count), 32'd5);
        checkOutput("spur.busy",  32'(bus.busy),      32'd1);
        applyStimulus(1'b0, 1'b1, none, "spur.retire");
        checkOutput("spur.retired", 32'(bus.job_count), 32'd6);

        // Watchdog scenario: done never arrives, a second job queued behind.
        applyStimulus(1'b1, 1'b0, randJob(), "wd.push1");
        applyStimulus(1'b1, 1'b0, randJob(), "wd.push2");
        busyCycles = 0;
        startSeen  = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, none, "wd.hold");
            if (bus.busy) busyCycles++;
            if (bus.start) startSeen++;
        end
`ifdef MC_DISPATCH_TIMEOUT_EN
        checkOutput("wd.err",        32'(bus.timeout_err), 32'd1);
        checkOutput("wd.count",      32'(bus.job_count),   32'd6);
        checkOutput("wd.nextIssued", 32'(startSeen > 0),   32'd1);
`else
        checkOutput("wd.busyCycles", 32'(busyCycles),      32'd100);
        checkOutput("wd.noErr",      32'(bus.timeout_err), 32'd0);
`endif
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, none, "wd.drain");

        // Reset while waiting with two jobs queued drops everything.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randJob(), "rw.push");
        applyStimulus(1'b0, 1'b0, none, "rw.wait");
        checkOutput("rw.inWait", 32'(bus.busy && !bus.start), 32'd1);
        applyReset("rst2");
        startSeen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, none, "rw.quiet");
            if (bus.start) startSeen++;
        end
        checkOutput("rw.noStart", 32'(startSeen), 32'd0);
        applyStimulus(1'b1, 1'b0, randJob(), "rw.newPush");
        applyStimulus(1'b0, 1'b0, none, "rw.newIssue");
        checkOutput("rw.newStart", 32'(bus.start), 32'd1);
        applyStimulus(1'b0, 1'b0, none, "rw.settle");

        // Random traffic against the model, including job_count wrap.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, randJob(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_op_dispatcher.md
# mc_op_dispatcher

Upstream job feeder for the multicycle datapath and its control FSM. Accepts operation requests (mode plus three operands) over a valid/ready port and buffers them in a small FIFO. Issues each job to the datapath by holding its operands stable and pulsing `start`, then waits for the controller's `done` before issuing the next. Also counts retired jobs.

## Interface
- `WIDTH`, 8: operand width in bits.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before abort; used only with the macro.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted on an edge where `in_valid & in_ready`.
- `in_mode`  in  1  operation select passed to the controller.
- `in_a`, `in_b`, `in_c`  in  WIDTH  operands.
- `start`  out  1  one-cycle issue pulse to the controller.
- `mode`  out  1  held mode of the issued job.
- `op_a`, `op_b`, `op_c`  out  WIDTH  held operands of the issued job.
- `done`  in  1  completion pulse from the controller.
- `busy`  out  1  high whenever the state is not IDLE.
- `job_count`  out  8  retired-job counter.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- FIFO:
  - Entry is {mode, a, b, c}.
  - `in_ready = !full`.
  - Push on `in_valid & in_ready`. Push and pop on the same edge are both honoured, so the count is unchanged.
  - No bypass: a pushed entry is poppable from the next edge on.
- FSM states:
  - **IDLE:** if the FIFO is non-empty, pop the head into the hold registers and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** `start = 1` for exactly this one cycle, then go to WAIT unconditionally.
  - **WAIT:** on `done`, go to IDLE and increment `job_count`.
- `mode` and `op_*` are driven only from the hold registers. They change only on a pop and stay stable through ISSUE and WAIT.
- `done` is ignored in IDLE and ISSUE. A spurious `done` has no effect.
- `job_count` wraps from 255 to 0.
- Reset:
  - All outputs are 0 except `in_ready`, which is 1.
  - State goes to IDLE and the FIFO is emptied.
  - Hold registers are 0 and `job_count` is 0.
  - Reset mid-job drops the in-flight job and all queued entries. No `start` is issued afterwards until a new push.

## Timing
- Acceptance edge E0 into an empty FIFO with the FSM in IDLE:
  - E1: pop, hold registers valid, enter ISSUE.
  - `start` is high between E1 and E2.
  - E2: enter WAIT.
- The controller samples `start` at E2.
- `done` sampled high at edge Ed: the FSM is in IDLE after Ed and `job_count` has incremented.
  - If the FIFO is non-empty, the next pop occurs at Ed+1 and the next `start` is high between Ed+1 and Ed+2.
- Minimum issue-to-issue spacing is 3 cycles plus the controller latency.
- Capacity is DEPTH queued entries plus one held job in flight.

## Configuration
- `MC_DISPATCH_TIMEOUT_EN` defined:
  - A cycle counter clears on WAIT entry and increments each cycle in WAIT.
  - If `done` has not arrived when the counter reaches `TIMEOUT`, set `timeout_err` (sticky until reset) and return to IDLE.
  - The aborted job is dropped and not counted.
  - `done` on the same cycle as the limit wins: normal retire, no error.
- Macro undefined:
  - No counter is built and WAIT lasts until `done`.
  - `timeout_err` is tied to 0, and the port remains present.

## Structure
- Shared package `mc_pkg` holds:
  - state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10);
  - the job record typedef {mode, a, b, c}.
- Natural sub-module: `mc_dispatch_fifo`.
  - Parameterised by WIDTH and DEPTH.
  - Circular buffer with a count register of width clog2(DEPTH)+1.
  - Provides `full` and `empty` flags.
- The dispatcher top holds the FSM, hold registers, counter and optional watchdog.

## Test plan
- **Reset:** assert `reset` mid-cycle.
  - Immediately: `start=0`, `busy=0`, `job_count=0`, `timeout_err=0`, `in_ready=1`, `op_*=0`.
- **Single job:** push mode=1, a=5, b=3, c=2 at E0.
  - `start` is high for one cycle after E1 with `op_a=5`, `op_b=3`, `op_c=2`, `mode=1`.
  - Model `done` 5 cycles later: `job_count=1`, `busy=0` after that edge.
- **Backpressure:** push back-to-back with `done` withheld.
  - Exactly 5 requests are accepted (E0–E4).
  - `in_ready=0` from E4 on.
  - Releasing `done` drains all 5 in order, with `job_count=5`.
- **Spurious done:** pulse `done` in IDLE and in ISSUE.
  - `job_count` is unchanged and the FSM is unaffected.
- **Watchdog:** `TIMEOUT=15`, `done` never arrives.
  - Macro on: `timeout_err=1` after 15 cycles in WAIT, FSM in IDLE, `job_count` unchanged, the next queued job still issues.
  - Macro off: `busy` stays 1 for 100 cycles.
- **Reset mid-WAIT with 2 queued:** after reset the FIFO is empty and `start` stays 0 for 20 cycles.
  - A new push then issues normally.
